fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage; owns the fetch PC, the instruction-memory request handshake and the IF/ID pipeline register.
- Feeds the decode-side controller its pc/inst pair.
- Consumes that controller's prediction, predicted target (new_pc) and hazard stall (NOP), plus the EX/MEM-stage mispredict recovery.
- Only stage allowed to change the architectural fetch PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, instruction driven on if_id_inst when slot invalid (addi x0,x0,0).

Ports:
- clk  in  1  clock; everything on posedge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hazard stall from controller NOP; freezes IF/ID and PC.
- pred_taken  in  1  controller prediction for the instruction now in IF/ID.
- pred_target  in  32  controller new_pc for the IF/ID instruction.
- mispredict  in  1  EX/MEM resolved a wrong prediction; flush and redirect.
- recover_pc  in  32  correct PC on mispredict.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts request; imem_rdata valid the same cycle.
- imem_rdata  in  32  fetched instruction.
- if_id_pc  out  32  PC of IF/ID instruction.
- if_id_inst  out  32  IF/ID instruction (NOP_INST when invalid).
- if_id_valid  out  1  IF/ID slot holds a live instruction.

Behaviour:
- Reset (rst=1 at posedge): pc_q=RESET_PC, state=BOOT, imem_req=0, if_id_valid=0, if_id_pc=0, if_id_inst=NOP_INST, buffer empty. Reset mid-transaction abandons the pending request; a late imem_ready is ignored.
- States:
  - BOOT: one idle cycle after reset, then FETCH.
  - FETCH: imem_req=1, imem_addr=pc_q.
  - HOLD: stalled with a buffered instruction, imem_req=0.
  - DROP: a pending request must complete, then be discarded.
- Handshake: imem_addr and imem_req stay stable while imem_req=1 and imem_ready=0. Exactly one outstanding request. Transfer = imem_req & imem_ready.
- Priority per cycle: mispredict > stall > pred_taken > sequential.
- Sequential (FETCH, transfer, no stall, no redirect): if_id_{pc,inst}<={pc_q,imem_rdata}, if_id_valid<=1, pc_q<=pc_q+4 (32-bit wrap, 32'hFFFF_FFFC -> 0). Latency request->IF/ID = 1 cycle after transfer.
- FETCH, no transfer, no stall, no redirect: if_id_valid<=0 (bubble).
- Stall: IF/ID and pc_q hold.
  - Transfer during stall: instruction goes to a 1-entry buffer (buf_pc, buf_inst), pc_q<=pc_q+4, state->HOLD.
  - When stall drops in HOLD: buffer moves to IF/ID, buffer empties, ->FETCH.
- Predicted redirect (if_id_valid & pred_taken & ~stall):
  - pc_q<=pred_target; if_id_valid<=0 (the sequential fetch in this cycle is squashed).
  - If a request is pending without transfer ->DROP, then FETCH at pred_target after the dropped transfer.
- Mispredict: if_id_valid<=0, buffer cleared, pc_q<=recover_pc, overrides stall. Pending request without transfer ->DROP; otherwise ->FETCH next cycle.
- Mispredict in DROP: updates the target PC, remains in DROP.
- Misaligned targets: bits [1:0] of pred_target/recover_pc are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetch_cnt[31:0] (transfers accepted into IF/ID or buffer) and perf_flush_cnt[31:0] (predicted redirects + mispredicts). Both reset to 0, saturate at 32'hFFFF_FFFF.
- Undefined: no counters, no extra ports; behaviour otherwise identical.

Decomposition:
- Shared package cpu_pkg: opcode constants (OP_BRANCH 7'b1100011, OP_JAL 7'b1101111, OP_JALR 7'b1100111), NOP_INST, fetch FSM state typedef (BOOT, FETCH, HOLD, DROP).
- Natural sub-module: fetch_skid_buf, the 1-entry stall buffer with load/drain/clear controls.

Test Plan:
- Reset then imem_ready=1 always:
  - imem_addr 0x0, 0x4, 0x8 on consecutive cycles after BOOT.
  - if_id_pc trails imem_addr by one cycle; if_id_valid rises on the 3rd cycle after rst falls.
- Stall=1 for 3 cycles with transfer at 0x10:
  - IF/ID frozen; 0x10 is buffered; imem_req=0 while held.
  - On stall release IF/ID=0x10 and fetch resumes at 0x14.
- IF/ID holds a branch at 0x20, pred_taken=1, pred_target=0x80:
  - Next imem_addr=0x80; the 0x24 fetch never reaches IF/ID.
- mispredict=1, recover_pc=0x40 while imem_ready=0 with request at 0x28 pending:
  - Addr 0x28 held until ready; its data is dropped.
  - Next request at 0x40; if_id_valid=0 throughout.
- mispredict and stall together: redirect to recover_pc wins; buffer is cleared.
- rst asserted in HOLD: all outputs return to reset values next cycle; first fetch at RESET_PC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the canonical NOP and the fetch FSM state type.
// Also provides a word-alignment helper for redirect targets.
package cpu_pkg;

  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;

  localparam logic [31:0] NOP_INST  = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    DROP  = 2'd3
  } fetch_state_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry buffer that catches an instruction returned while decode is stalled.
// Priority: clear > load > drain.
module fetch_skid_buf #(
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        drain,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_inst,
  output logic        buf_valid,
  output logic [31:0] buf_pc,
  output logic [31:0] buf_inst
);

  logic        valid_q, valid_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] inst_q,  inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      inst_d  = load_inst;
    end else if (drain) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= 32'h0;
      inst_q  <= NOP_INST;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign buf_valid = valid_q;
  assign buf_pc    = pc_q;
  assign buf_inst  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: fetch PC, imem handshake and the IF/ID register.
// Define FETCH_PERF_CNT_EN to add saturating fetch/flush performance counters.
//
// state | meaning
// BOOT  | one idle cycle after reset, no request
// FETCH | request outstanding at pc_q
// HOLD  | stalled with an instruction parked in the skid buffer, no request
// DROP  | request at drop_addr_q must finish, its data is discarded
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  input  logic        mispredict,
  input  logic [31:0] recover_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  import cpu_pkg::*;

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q,          pc_d;
  logic [31:0]  drop_addr_q,   drop_addr_d;
  logic [31:0]  if_id_pc_q,    if_id_pc_d;
  logic [31:0]  if_id_inst_q,  if_id_inst_d;
  logic         if_id_valid_q, if_id_valid_d;

  logic         xfer;
  logic         redirect;
  logic [31:0]  rec_pc;
  logic [31:0]  tgt_pc;
  logic [31:0]  pc_inc;

  logic         buf_load, buf_drain, buf_clear;
  logic         buf_valid;
  logic [31:0]  buf_pc, buf_inst;

  logic         fetch_evt, flush_evt;

  assign imem_req  = (state_q == FETCH) || (state_q == DROP);
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;

  assign xfer     = imem_req & imem_ready;
  assign redirect = if_id_valid_q & pred_taken & ~stall;
  assign rec_pc   = word_align(recover_pc);
  assign tgt_pc   = word_align(pred_target);
  assign pc_inc   = pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_inst_d  = if_id_inst_q;
    if_id_valid_d = if_id_valid_q;
    buf_load      = 1'b0;
    buf_drain     = 1'b0;
    buf_clear     = 1'b0;
    fetch_evt     = 1'b0;
    flush_evt     = 1'b0;

    case (state_q)
      BOOT: begin
        state_d = FETCH;
        if (mispredict) begin
          pc_d          = rec_pc;
          if_id_valid_d = 1'b0;
          buf_clear     = 1'b1;
          flush_evt     = 1'b1;
        end
      end

      FETCH: begin
        if (mispredict) begin
          pc_d          = rec_pc;
          if_id_valid_d = 1'b0;
          buf_clear     = 1'b1;
          flush_evt     = 1'b1;
          if (!xfer) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (stall) begin
          if (xfer) begin
            buf_load  = 1'b1;
            pc_d      = pc_inc;
            state_d   = HOLD;
            fetch_evt = 1'b1;
          end
        end else if (redirect) begin
          // The sequential fetch completing this cycle belongs to the wrong path.
          pc_d          = tgt_pc;
          if_id_valid_d = 1'b0;
          flush_evt     = 1'b1;
          if (!xfer) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end else if (xfer) begin
          if_id_pc_d    = pc_q;
          if_id_inst_d  = imem_rdata;
          if_id_valid_d = 1'b1;
          pc_d          = pc_inc;
          fetch_evt     = 1'b1;
        end else begin
          if_id_valid_d = 1'b0;
        end
      end

      HOLD: begin
        if (mispredict) begin
          pc_d          = rec_pc;
          if_id_valid_d = 1'b0;
          buf_clear     = 1'b1;
          state_d       = FETCH;
          flush_evt     = 1'b1;
        end else if (!stall) begin
          state_d = FETCH;
          if (redirect) begin
            // Buffered instruction is the fall-through of a taken prediction.
            pc_d          = tgt_pc;
            if_id_valid_d = 1'b0;
            buf_clear     = 1'b1;
            flush_evt     = 1'b1;
          end else begin
            if_id_pc_d    = buf_pc;
            if_id_inst_d  = buf_inst;
            if_id_valid_d = buf_valid;
            buf_drain     = 1'b1;
          end
        end
      end

      DROP: begin
        if (mispredict) begin
          pc_d          = rec_pc;
          if_id_valid_d = 1'b0;
          buf_clear     = 1'b1;
          flush_evt     = 1'b1;
        end
        if (xfer) begin
          state_d = FETCH;
        end
      end

      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      drop_addr_q   <= RESET_PC;
      if_id_pc_q    <= 32'h0;
      if_id_inst_q  <= NOP_INST;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_inst_q  <= if_id_inst_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  fetch_skid_buf #(
    .NOP_INST (NOP_INST)
  ) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .drain     (buf_drain),
    .clear     (buf_clear),
    .load_pc   (pc_q),
    .load_inst (imem_rdata),
    .buf_valid (buf_valid),
    .buf_pc    (buf_pc),
    .buf_inst  (buf_inst)
  );

  assign if_id_pc    = if_id_pc_q;
  assign if_id_inst  = if_id_valid_q ? if_id_inst_q : NOP_INST;
  assign if_id_valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = perf_fetch_q;
    perf_flush_d = perf_flush_q;
    if (fetch_evt && (perf_fetch_q != 32'hFFFF_FFFF)) perf_fetch_d = perf_fetch_q + 32'd1;
    if (flush_evt && (perf_flush_q != 32'hFFFF_FFFF)) perf_flush_d = perf_flush_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetch_q <= 32'h0;
      perf_flush_q <= 32'h0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
`else
  logic unused_perf;
  assign unused_perf = fetch_evt ^ flush_evt;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: sequential fetch, stall buffering, predicted
// redirect, mispredict drop, combined mispredict/stall, reset in HOLD, PC wrap.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, stall, pred_taken, mispredict, imem_ready;
  logic [31:0] pred_target, recover_pc, imem_rdata;
  logic        imem_req, if_id_valid;
  logic [31:0] imem_addr, if_id_pc, if_id_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_flush_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Memory returns a recognisable pattern derived from the address.
  assign imem_rdata = imem_addr ^ 32'h5500_0000;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .mispredict  (mispredict),
    .recover_pc  (recover_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .if_id_pc    (if_id_pc),
    .if_id_inst  (if_id_inst),
    .if_id_valid (if_id_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; pred_taken = 1'b0; mispredict = 1'b0;
    imem_ready = 1'b1; pred_target = 32'h0; recover_pc = 32'h0;

    tick();
    check("rst_req",   {31'd0, imem_req},    32'd0);
    check("rst_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst_pc",    if_id_pc,             32'h0);
    check("rst_inst",  if_id_inst,           32'h0000_0013);
    rst = 1'b0;

    tick();
    check("boot_req",   {31'd0, imem_req},    32'd1);
    check("boot_addr",  imem_addr,            32'h0);
    check("boot_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    check("seq0_addr",  imem_addr,            32'h4);
    check("seq0_valid", {31'd0, if_id_valid}, 32'd1);
    check("seq0_pc",    if_id_pc,             32'h0);
    check("seq0_inst",  if_id_inst,           32'h5500_0000);
    tick();
    check("seq1_addr",  imem_addr,            32'h8);
    check("seq1_pc",    if_id_pc,             32'h4);
    tick();
    check("seq2_addr",  imem_addr,            32'hC);
    tick();
    check("seq3_addr",  imem_addr,            32'h10);
    check("seq3_pc",    if_id_pc,             32'hC);

    stall = 1'b1;
    tick();
    check("stall0_req", {31'd0, imem_req},    32'd0);
    check("stall0_pc",  if_id_pc,             32'hC);
    check("stall0_vld", {31'd0, if_id_valid}, 32'd1);
    tick();
    check("stall1_req", {31'd0, imem_req},    32'd0);
    check("stall1_pc",  if_id_pc,             32'hC);
    tick();
    check("stall2_req", {31'd0, imem_req},    32'd0);
    stall = 1'b0;
    tick();
    check("unstall_pc",   if_id_pc,  32'h10);
    check("unstall_inst", if_id_inst, 32'h5500_0010);
    check("unstall_addr", imem_addr, 32'h14);
    check("unstall_req",  {31'd0, imem_req}, 32'd1);

    tick(); tick(); tick(); tick();
    check("br_pc",   if_id_pc,  32'h20);
    check("br_addr", imem_addr, 32'h24);
    pred_taken = 1'b1; pred_target = 32'h0000_0083;
    tick();
    check("pred_addr",  imem_addr,            32'h80);
    check("pred_valid", {31'd0, if_id_valid}, 32'd0);
    pred_taken = 1'b0;
    tick();
    check("tgt_pc",    if_id_pc,             32'h80);
    check("tgt_valid", {31'd0, if_id_valid}, 32'd1);
    check("tgt_addr",  imem_addr,            32'h84);

    mispredict = 1'b1; recover_pc = 32'h28;
    tick();
    check("mp0_addr",  imem_addr,            32'h28);
    check("mp0_valid", {31'd0, if_id_valid}, 32'd0);
    mispredict = 1'b0; imem_ready = 1'b0;
    tick();
    check("wait_addr", imem_addr, 32'h28);
    mispredict = 1'b1; recover_pc = 32'h40;
    tick();
    check("drop0_addr",  imem_addr,            32'h28);
    check("drop0_req",   {31'd0, imem_req},    32'd1);
    check("drop0_valid", {31'd0, if_id_valid}, 32'd0);
    mispredict = 1'b0;
    tick();
    check("drop1_addr",  imem_addr,            32'h28);
    check("drop1_valid", {31'd0, if_id_valid}, 32'd0);
    imem_ready = 1'b1;
    tick();
    check("rec_addr",  imem_addr,            32'h40);
    check("rec_valid", {31'd0, if_id_valid}, 32'd0);
    tick();
    check("rec_pc",   if_id_pc,   32'h40);
    check("rec_inst", if_id_inst, 32'h5500_0040);

    stall = 1'b1;
    tick();
    check("hold_req", {31'd0, imem_req}, 32'd0);
    mispredict = 1'b1; recover_pc = 32'h100;
    tick();
    check("mpst_addr",  imem_addr,            32'h100);
    check("mpst_valid", {31'd0, if_id_valid}, 32'd0);
    check("mpst_req",   {31'd0, imem_req},    32'd1);
    mispredict = 1'b0; stall = 1'b0;
    tick();
    check("mpst_pc", if_id_pc, 32'h100);

    stall = 1'b1;
    tick();
    check("hold2_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    tick();
    check("rst2_req",   {31'd0, imem_req},    32'd0);
    check("rst2_valid", {31'd0, if_id_valid}, 32'd0);
    check("rst2_pc",    if_id_pc,             32'h0);
    check("rst2_inst",  if_id_inst,           32'h0000_0013);
    rst = 1'b0; stall = 1'b0;
    tick();
    check("rst2_addr", imem_addr, 32'h0);
    tick();
    check("rst2_fpc", if_id_pc, 32'h0);

    mispredict = 1'b1; recover_pc = 32'hFFFF_FFFE;
    tick();
    check("wrap0_addr", imem_addr, 32'hFFFF_FFFC);
    mispredict = 1'b0;
    tick();
    check("wrap_pc",   if_id_pc,  32'hFFFF_FFFC);
    check("wrap_addr", imem_addr, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
